// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file: byte size and the
// byte-masked merge used by both the storage write path and the read bypass.
package regfile_pkg;

    localparam int REGFILE_BYTE = 8;

    typedef logic [REGFILE_BYTE-1:0] byte_t;

    function automatic byte_t byte_merge(input byte_t old_byte,
                                         input byte_t new_byte,
                                         input logic  mask);
        return mask ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: write-first bypass with byte merge, optional
// zero-register override (REGFILE_ZERO_REG_EN), and the output flop.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rd_en,
    input  logic [AW-1:0]             rd_addr,
    input  logic [WIDTH-1:0]          mem_word,
    input  logic                      wr,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH/REGFILE_BYTE-1:0] byte_en,
    input  logic [WIDTH-1:0]          data_in,
    output logic [WIDTH-1:0]          data_out
);

    localparam int NB = WIDTH / REGFILE_BYTE;

    typedef logic [AW-1:0] addr_t;

    addr_t            rd_addr_q;
    logic [WIDTH-1:0] next_word;

    assign rd_addr_q = rd_addr;

    // A same-cycle write to the read address is merged in so the port sees
    // the word as it will be after this edge.
    always_comb begin
        next_word = mem_word;
        if (wr && (wr_addr == rd_addr_q)) begin
            for (int b = 0; b < NB; b++) begin
                next_word[b*REGFILE_BYTE +: REGFILE_BYTE] =
                    byte_merge(mem_word[b*REGFILE_BYTE +: REGFILE_BYTE],
                               data_in[b*REGFILE_BYTE +: REGFILE_BYTE],
                               byte_en[b]);
            end
        end
`ifdef REGFILE_ZERO_REG_EN
        if (rd_addr_q == '0) begin
            next_word = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else if (rd_en) begin
            data_out <= next_word;
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// DEPTH x WIDTH register file, one byte-enabled write port and two registered
// read ports. Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module register_file_2r1w
    import regfile_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Wr,
    input  logic [AW-1:0]                 Wr_addr,
    input  logic [WIDTH/REGFILE_BYTE-1:0] Byte_en,
    input  logic [WIDTH-1:0]              Data_in,
    input  logic                          Rd_en_a,
    input  logic [AW-1:0]                 Rd_addr_a,
    output logic [WIDTH-1:0]              Data_out_a,
    input  logic                          Rd_en_b,
    input  logic [AW-1:0]                 Rd_addr_b,
    output logic [WIDTH-1:0]              Data_out_b
);

    localparam int NB = WIDTH / REGFILE_BYTE;

    // No handshake: every port accepts a request on every edge, there is no
    // valid/ready pair and nothing ever stalls.

`ifdef REGFILE_ZERO_REG_EN
    localparam int LO = 1;
`else
    localparam int LO = 0;
`endif

    logic [WIDTH-1:0] store [DEPTH-1:LO];
    logic             wr_ok;
    logic [WIDTH-1:0] word_a;
    logic [WIDTH-1:0] word_b;

`ifdef REGFILE_ZERO_REG_EN
    assign wr_ok  = Wr && (Wr_addr != '0);
    assign word_a = (Rd_addr_a == '0) ? '0 : store[Rd_addr_a];
    assign word_b = (Rd_addr_b == '0) ? '0 : store[Rd_addr_b];
`else
    assign wr_ok  = Wr;
    assign word_a = store[Rd_addr_a];
    assign word_b = store[Rd_addr_b];
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = LO; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
                store[Wr_addr][b*REGFILE_BYTE +: REGFILE_BYTE] <=
                    byte_merge(store[Wr_addr][b*REGFILE_BYTE +: REGFILE_BYTE],
                               Data_in[b*REGFILE_BYTE +: REGFILE_BYTE],
                               Byte_en[b]);
            end
        end
    end

    regfile_read_port #(.WIDTH(WIDTH), .AW(AW)) u_port_a (
        .clk      (Clk),
        .reset    (Reset),
        .rd_en    (Rd_en_a),
        .rd_addr  (Rd_addr_a),
        .mem_word (word_a),
        .wr       (Wr),
        .wr_addr  (Wr_addr),
        .byte_en  (Byte_en),
        .data_in  (Data_in),
        .data_out (Data_out_a)
    );

    regfile_read_port #(.WIDTH(WIDTH), .AW(AW)) u_port_b (
        .clk      (Clk),
        .reset    (Reset),
        .rd_en    (Rd_en_b),
        .rd_addr  (Rd_addr_b),
        .mem_word (word_b),
        .wr       (Wr),
        .wr_addr  (Wr_addr),
        .byte_en  (Byte_en),
        .data_in  (Data_in),
        .data_out (Data_out_b)
    );

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: reset, byte writes, read latency,
// write-first bypass, read hold and the optional zero register.
module tb_register_file_2r1w;

    logic        Clk;
    logic        Reset;
    logic        Wr;
    logic [4:0]  Wr_addr;
    logic [3:0]  Byte_en;
    logic [31:0] Data_in;
    logic        Rd_en_a;
    logic [4:0]  Rd_addr_a;
    logic [31:0] Data_out_a;
    logic        Rd_en_b;
    logic [4:0]  Rd_addr_b;
    logic [31:0] Data_out_b;

    int n_cmp;
    int n_fail;

    register_file_2r1w dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Wr         (Wr),
        .Wr_addr    (Wr_addr),
        .Byte_en    (Byte_en),
        .Data_in    (Data_in),
        .Rd_en_a    (Rd_en_a),
        .Rd_addr_a  (Rd_addr_a),
        .Data_out_a (Data_out_a),
        .Rd_en_b    (Rd_en_b),
        .Rd_addr_b  (Rd_addr_b),
        .Data_out_b (Data_out_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Reset   = 1'b0;
        Wr      = 1'b0;
        Rd_en_a = 1'b0;
        Rd_en_b = 1'b0;
        Byte_en = 4'h0;
    endtask

    task automatic write_word(input logic [4:0] addr, input logic [31:0] data,
                              input logic [3:0] be);
        Wr      = 1'b1;
        Wr_addr = addr;
        Data_in = data;
        Byte_en = be;
        step();
        idle();
    endtask

    task automatic read_both(input logic [4:0] aa, input logic [4:0] ab);
        Rd_en_a   = 1'b1;
        Rd_addr_a = aa;
        Rd_en_b   = 1'b1;
        Rd_addr_b = ab;
        step();
        idle();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        idle();
        write_word(5'd5, 32'h12345678, 4'hF);
        read_both(5'd5, 5'd5);
        n_cmp++;
        if (Data_out_a !== 32'h12345678) begin
            n_fail++;
            $display("FAIL pre_reset_a got=%h exp=%h", Data_out_a, 32'h12345678);
        end
        // Reset together with a write and reads on the same edge
        Reset = 1'b1; Wr = 1'b1; Wr_addr = 5'd5; Data_in = 32'hFFFFFFFF; Byte_en = 4'hF;
        Rd_en_a = 1'b1; Rd_addr_a = 5'd5; Rd_en_b = 1'b1; Rd_addr_b = 5'd5;
        step();
        idle();
        n_cmp++;
        if (Data_out_a !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_a got=%h exp=%h", Data_out_a, 32'h0);
        end
        n_cmp++;
        if (Data_out_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_b got=%h exp=%h", Data_out_b, 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            read_both(5'(i), 5'(31 - i));
            n_cmp++;
            if (Data_out_a !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_clear_a addr=%0d got=%h exp=%h", i, Data_out_a, 32'h0);
            end
            n_cmp++;
            if (Data_out_b !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_clear_b addr=%0d got=%h exp=%h", 31 - i, Data_out_b, 32'h0);
            end
        end
    endtask

    task automatic test_full_write();
        write_word(5'd7, 32'h55555555, 4'hF);
        Rd_en_a   = 1'b1;
        Rd_addr_a = 5'd7;
        #1;
        n_cmp++;
        if (Data_out_a !== 32'h0) begin
            n_fail++;
            $display("FAIL latency_early got=%h exp=%h", Data_out_a, 32'h0);
        end
        step();
        idle();
        n_cmp++;
        if (Data_out_a !== 32'h55555555) begin
            n_fail++;
            $display("FAIL full_write got=%h exp=%h", Data_out_a, 32'h55555555);
        end
        n_cmp++;
        if (Data_out_b !== 32'h0) begin
            n_fail++;
            $display("FAIL full_write_b_hold got=%h exp=%h", Data_out_b, 32'h0);
        end
    endtask

    task automatic test_partial_write();
        write_word(5'd3, 32'h11223344, 4'hF);
        write_word(5'd3, 32'hAABBCCDD, 4'b0101);
        read_both(5'd7, 5'd3);
        n_cmp++;
        if (Data_out_b !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL partial_write got=%h exp=%h", Data_out_b, 32'h11BB33DD);
        end
        write_word(5'd3, 32'hFFFFFFFF, 4'h0);
        read_both(5'd3, 5'd3);
        n_cmp++;
        if (Data_out_a !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL zero_mask_noop got=%h exp=%h", Data_out_a, 32'h11BB33DD);
        end
    endtask

    task automatic test_bypass();
        Wr = 1'b1; Wr_addr = 5'd9; Data_in = 32'hCAFEF00D; Byte_en = 4'b0011;
        Rd_en_a = 1'b1; Rd_addr_a = 5'd9; Rd_en_b = 1'b1; Rd_addr_b = 5'd9;
        step();
        idle();
        n_cmp++;
        if (Data_out_a !== 32'h0000F00D) begin
            n_fail++;
            $display("FAIL bypass_a got=%h exp=%h", Data_out_a, 32'h0000F00D);
        end
        n_cmp++;
        if (Data_out_b !== 32'h0000F00D) begin
            n_fail++;
            $display("FAIL bypass_b got=%h exp=%h", Data_out_b, 32'h0000F00D);
        end
        // Bypass merging into a non-zero old word on port A only
        Wr = 1'b1; Wr_addr = 5'd3; Data_in = 32'h99887766; Byte_en = 4'b1100;
        Rd_en_a = 1'b1; Rd_addr_a = 5'd3;
        step();
        idle();
        n_cmp++;
        if (Data_out_a !== 32'h998833DD) begin
            n_fail++;
            $display("FAIL bypass_merge got=%h exp=%h", Data_out_a, 32'h998833DD);
        end
        read_both(5'd9, 5'd3);
        n_cmp++;
        if (Data_out_a !== 32'h0000F00D) begin
            n_fail++;
            $display("FAIL bypass_stored got=%h exp=%h", Data_out_a, 32'h0000F00D);
        end
        n_cmp++;
        if (Data_out_b !== 32'h998833DD) begin
            n_fail++;
            $display("FAIL merge_stored got=%h exp=%h", Data_out_b, 32'h998833DD);
        end
    endtask

    task automatic test_hold_dual();
        write_word(5'd1, 32'h1, 4'hF);
        write_word(5'd2, 32'h2, 4'hF);
        read_both(5'd1, 5'd2);
        write_word(5'd1, 32'hAAAAAAAA, 4'hF);
        write_word(5'd2, 32'hBBBBBBBB, 4'hF);
        step();
        n_cmp++;
        if (Data_out_a !== 32'h1) begin
            n_fail++;
            $display("FAIL hold_a got=%h exp=%h", Data_out_a, 32'h1);
        end
        n_cmp++;
        if (Data_out_b !== 32'h2) begin
            n_fail++;
            $display("FAIL hold_b got=%h exp=%h", Data_out_b, 32'h2);
        end
        read_both(5'd1, 5'd1);
        n_cmp++;
        if (Data_out_a !== 32'hAAAAAAAA) begin
            n_fail++;
            $display("FAIL same_addr_a got=%h exp=%h", Data_out_a, 32'hAAAAAAAA);
        end
        n_cmp++;
        if (Data_out_b !== 32'hAAAAAAAA) begin
            n_fail++;
            $display("FAIL same_addr_b got=%h exp=%h", Data_out_b, 32'hAAAAAAAA);
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] exp_plain;
        logic [31:0] exp_byp;
`ifdef REGFILE_ZERO_REG_EN
        exp_plain = 32'h0;
        exp_byp   = 32'h0;
`else
        exp_plain = 32'hDEADBEEF;
        exp_byp   = 32'h01020304;
`endif
        write_word(5'd0, 32'hDEADBEEF, 4'hF);
        read_both(5'd0, 5'd0);
        n_cmp++;
        if (Data_out_a !== exp_plain) begin
            n_fail++;
            $display("FAIL reg0_plain got=%h exp=%h", Data_out_a, exp_plain);
        end
        Wr = 1'b1; Wr_addr = 5'd0; Data_in = 32'h01020304; Byte_en = 4'hF;
        Rd_en_a = 1'b1; Rd_addr_a = 5'd0; Rd_en_b = 1'b1; Rd_addr_b = 5'd0;
        step();
        idle();
        n_cmp++;
        if (Data_out_b !== exp_byp) begin
            n_fail++;
            $display("FAIL reg0_bypass got=%h exp=%h", Data_out_b, exp_byp);
        end
        read_both(5'd7, 5'd0);
        n_cmp++;
        if (Data_out_b !== exp_byp) begin
            n_fail++;
            $display("FAIL reg0_after got=%h exp=%h", Data_out_b, exp_byp);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        Wr_addr   = '0;
        Data_in   = '0;
        Rd_addr_a = '0;
        Rd_addr_b = '0;
        idle();
        test_reset();
        test_full_write();
        test_partial_write();
        test_bypass();
        test_hold_dual();
        test_zero_reg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised multi-register successor to the single 32-bit register.
- DEPTH registers of WIDTH bits; one write port with byte enables; two independent read ports with registered outputs.
- Serves as the CPU datapath register file. The write-back stage drives the write port; decode drives reads A/B.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; power of two, >= 2.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Wr  input  1  write enable
- Wr_addr  input  AW  write address
- Byte_en  input  WIDTH/8  per-byte write mask; bit i covers Data_in[8i+7:8i]
- Data_in  input  WIDTH  write data
- Rd_en_a  input  1  read enable, port A
- Rd_addr_a  input  AW  read address, port A
- Data_out_a  output  WIDTH  registered read data, port A
- Rd_en_b  input  1  read enable, port B
- Rd_addr_b  input  AW  read address, port B
- Data_out_b  output  WIDTH  registered read data, port B

Behaviour:
- Reset
  - Reset=1 at a rising edge clears all DEPTH registers, Data_out_a and Data_out_b to 0.
  - Reset dominates Wr and Rd_en_x in the same cycle: no write, and outputs read 0.
  - Reset sampled mid-sequence discards any in-flight write that cycle.
- Write
  - When Wr=1 and Reset=0 at an edge, each byte i with Byte_en[i]=1 updates mem[Wr_addr].
  - Bytes with Byte_en[i]=0 retain their old value.
  - Wr=1 with Byte_en all zero is a no-op.
- Read latency
  - 1 cycle. If Rd_en_x=1 at edge k, Data_out_x shows the word for Rd_addr_x after edge k.
  - If Rd_en_x=0, Data_out_x holds its previous value.
- Read-during-write
  - Write-first. If Wr=1 and Rd_en_x=1 with Rd_addr_x==Wr_addr in the same cycle, Data_out_x gets the merged word: new bytes where Byte_en=1, old bytes elsewhere.
- Port conflicts
  - Both read ports may target the same address simultaneously; each returns an identical value.
  - No port conflicts exist; no stall or handshake.
- Addresses
  - Every AW-bit address is valid (DEPTH is a power of two); no wrap or out-of-range case.
- Outputs are driven only from flops; no combinational path from inputs to Data_out_x.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero; writes to address 0 are discarded.
  - A read of address 0 returns 0, including in the write-first bypass case (Wr_addr=0, Rd_addr=0).
  - Storage for entry 0 is not synthesised.
- Undefined: register 0 behaves like every other entry.

Decomposition:
- Shared package regfile_pkg:
  - localparam REGFILE_BYTE = 8
  - function byte_merge(old, new, mask), returning the byte-masked combination; used by both the write path and the bypass path.
  - typedef for the address type, parameterised via AW at the instance.
- One natural sub-module, regfile_read_port: address-match bypass, byte merge, zero-register override and output flop.
  - Instantiated twice (A, B) to guarantee identical port behaviour.

Test Plan:
- Reset clears storage: after Reset=1 for 1 cycle, read addrs 0..31 on A and B -> all outputs 32'h0; Reset asserted alongside Wr=1, addr 5, data 32'hFFFFFFFF -> later read of addr 5 gives 32'h0.
- Full write and latency: write 32'h55555555 to addr 7 with Byte_en=4'hF, then Rd_en_a=1, addr 7 -> Data_out_a=32'h55555555 exactly one edge later, not before.
- Partial write: preload addr 3 = 32'h11223344, then write 32'hAABBCCDD with Byte_en=4'b0101 -> read gives 32'h11BB33DD.
- Write-first bypass: addr 9 holds 32'h0; same cycle Wr=1, addr 9, data 32'hCAFEF00D, Byte_en=4'b0011, Rd_en_a=Rd_en_b=1, both addr 9 -> both outputs 32'h0000F00D next edge.
- Hold and dual read: read addr 1 (32'h1) on A and addr 2 (32'h2) on B, then drop both Rd_en and write addrs 1 and 2 -> outputs stay 32'h1 and 32'h2.
- Zero register (macro defined): write 32'hDEADBEEF to addr 0, with and without simultaneous read of addr 0 -> Data_out always 32'h0; macro undefined -> 32'hDEADBEEF.
